proc_control: RTL and testbench

- Control unit for the simple 16-bit processor.
- Latches a 9-bit instruction from din, sequences it over 2–4 clock steps, and drives the bus-source selects consumed by the bus multiplexer (r0_out..r7_out, din_out, g_out) plus the register-load enables and ALU control.
- Guarantees at most one bus source is asserted per cycle.

---
 rtl/proc_control.sv | 138 +++++++++++++
 tb/tb_proc_control.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_control.sv
`default_nettype none
// ============================================================================
// Module  : proc_control
// Brief   : Instruction sequencer for the simple 16-bit processor; it drives
//           the bus-source selects, register-load enables and ALU control.
// Revision: 1.0  initial release
// ============================================================================
module proc_control #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  run,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [7:0]            r_out,
   output logic                  din_out,
   output logic                  g_out,
   output logic [7:0]            r_in,
   output logic                  a_in,
   output logic                  g_in,
   output logic                  addsub,
   output logic                  ir_in,
   output logic                  done,
   output logic [1:0]            tstep
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } step_t;

   localparam logic [2:0] c_op_mv  = 3'b000;
   localparam logic [2:0] c_op_mvi = 3'b001;
   localparam logic [2:0] c_op_add = 3'b010;
   localparam logic [2:0] c_op_sub = 3'b011;

   step_t      r_step;
   step_t      w_step_nxt;
   logic [8:0] r_ir;
   logic [2:0] w_op;
   logic [7:0] w_x_sel;
   logic [7:0] w_y_sel;
   logic       w_arith;
   logic       w_din_unused;

   assign w_op    = r_ir[8:6];
   assign w_x_sel = 8'b1 << r_ir[5:3];
   assign w_y_sel = 8'b1 << r_ir[2:0];
   assign w_arith = (w_op == c_op_add) || (w_op == c_op_sub);

   // Immediate data on din is routed by the external bus mux, not used here.
   assign w_din_unused = ^din[DATA_WIDTH-10:0];

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_step <= T0;
         r_ir   <= '0;
      end else begin
         r_step <= w_step_nxt;
         if (ir_in) begin
            r_ir <= din[DATA_WIDTH-1 -: 9];
         end
      end
   end

   always_comb begin
      r_out      = '0;
      din_out    = 1'b0;
      g_out      = 1'b0;
      r_in       = '0;
      a_in       = 1'b0;
      g_in       = 1'b0;
      addsub     = 1'b0;
      ir_in      = 1'b0;
      done       = 1'b0;
      tstep      = 2'd0;
      w_step_nxt = r_step;

      // Everything stays quiet while reset is held so no register is written.
      if (resetn) begin
         tstep = r_step;
         case (r_step)
            T0: begin
               if (run) begin
                  ir_in      = 1'b1;
                  w_step_nxt = T1;
               end
            end
            T1: begin
               case (w_op)
                  c_op_mv: begin
                     r_out      = w_y_sel;
                     r_in       = w_x_sel;
                     done       = 1'b1;
                     w_step_nxt = T0;
                  end
                  c_op_mvi: begin
                     din_out    = 1'b1;
                     r_in       = w_x_sel;
                     done       = 1'b1;
                     w_step_nxt = T0;
                  end
                  c_op_add, c_op_sub: begin
                     r_out      = w_x_sel;
                     a_in       = 1'b1;
                     w_step_nxt = T2;
                  end
                  default: begin
                     done       = 1'b1;
                     w_step_nxt = T0;
                  end
               endcase
            end
            T2: begin
               w_step_nxt = T0;
               if (w_arith) begin
                  r_out      = w_y_sel;
                  g_in       = 1'b1;
                  addsub     = (w_op == c_op_sub);
                  w_step_nxt = T3;
               end
            end
            T3: begin
               w_step_nxt = T0;
               if (w_arith) begin
                  g_out = 1'b1;
                  r_in  = w_x_sel;
                  done  = 1'b1;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_proc_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_proc_control
// Brief   : Directed and random stimulus for proc_control with an output
//           schedule model and per-cycle invariant checks.
// Revision: 1.0  initial release
// ============================================================================
module tb_proc_control;

   logic        clock = 1'b0;
   logic        resetn;
   logic        run;
   logic [15:0] din;
   logic [7:0]  r_out;
   logic        din_out;
   logic        g_out;
   logic [7:0]  r_in;
   logic        a_in;
   logic        g_in;
   logic        addsub;
   logic        ir_in;
   logic        done;
   logic [1:0]  tstep;

   int          checks = 0;
   int          errors = 0;
   logic        lit_en = 1'b0;
   logic [24:0] lit_exp = '0;
   string       lit_name = "";
   logic [24:0] sched[$];

   proc_control #(.DATA_WIDTH(16)) dut (
      .clock  (clock),
      .resetn (resetn),
      .run    (run),
      .din    (din),
      .r_out  (r_out),
      .din_out(din_out),
      .g_out  (g_out),
      .r_in   (r_in),
      .a_in   (a_in),
      .g_in   (g_in),
      .addsub (addsub),
      .ir_in  (ir_in),
      .done   (done),
      .tstep  (tstep)
   );

   always #5 clock = ~clock;

   function automatic logic [24:0] vec(input logic [7:0] ro, input logic dio, input logic go,
                                       input logic [7:0] ri, input logic ai, input logic gi,
                                       input logic asb, input logic iri, input logic dn,
                                       input logic [1:0] ts);
      return {ro, dio, go, ri, ai, gi, asb, iri, dn, ts};
   endfunction

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
      return {op, x, y, 7'd0};
   endfunction

   function automatic logic [7:0] oh(input logic [2:0] i);
      logic [7:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_ok(input string nm, input logic ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL %s: got violated expected held at %0t", nm, $time);
      end
   endtask

   // Queue the per-cycle output pattern an accepted instruction must produce.
   task automatic plan(input logic [8:0] ins);
      logic [2:0] op, x, y;
      {op, x, y} = ins;
      case (op)
         3'b000: sched.push_back(vec(oh(y), 0, 0, oh(x), 0, 0, 0, 0, 1, 2'd1));
         3'b001: sched.push_back(vec(8'h00, 1, 0, oh(x), 0, 0, 0, 0, 1, 2'd1));
         3'b010, 3'b011: begin
            sched.push_back(vec(oh(x), 0, 0, 8'h00, 1, 0, 0, 0, 0, 2'd1));
            sched.push_back(vec(oh(y), 0, 0, 8'h00, 0, 1, op[0], 0, 0, 2'd2));
            sched.push_back(vec(8'h00, 0, 1, oh(x), 0, 0, 0, 0, 1, 2'd3));
         end
         default: sched.push_back(vec(8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 2'd1));
      endcase
   endtask

   always @(negedge clock) begin
      logic [24:0] act, exp;
      act = {r_out, din_out, g_out, r_in, a_in, g_in, addsub, ir_in, done, tstep};
      exp = '0;
      if (resetn !== 1'b1) begin
         sched.delete();
      end else if (sched.size() > 0) begin
         exp = sched.pop_front();
      end else if (run) begin
         exp = vec(8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 2'd0);
         plan(din[15:7]);
      end
      chk("model", act, exp);
      chk_ok("bus_onehot", $countones({r_out, din_out, g_out}) <= 1);
      chk_ok("rin_onehot", $countones(r_in) <= 1);
      chk_ok("load_excl", $countones({a_in, g_in, |r_in}) <= 1);
      if (lit_en) chk(lit_name, act, lit_exp);
   end

   task automatic cyc(input logic rn, input logic r, input logic [15:0] d);
      @(posedge clock);
      #1;
      resetn = rn;
      run    = r;
      din    = d;
      lit_en = 1'b0;
   endtask

   task automatic lit(input string nm, input logic [24:0] e);
      lit_name = nm;
      lit_exp  = e;
      lit_en   = 1'b1;
   endtask

   localparam logic [24:0] c_zero = 25'd0;
   localparam logic [24:0] c_ir   = 25'b0000_0000_0_0_0000_0000_0_0_0_1_0_00;

   initial begin
      resetn = 1'b0;
      run    = 1'b1;
      din    = 16'hFFFF;

      cyc(0, 1, 16'hFFFF); lit("rst_a", c_zero);
      cyc(0, 1, 16'hFFFF); lit("rst_b", c_zero);
      cyc(1, 0, 16'h0000); lit("idle", c_zero);

      // mvi R2,#5
      cyc(1, 1, enc(3'd1, 3'd2, 3'd0)); lit("mvi_t0", c_ir);
      cyc(1, 0, 16'h0005); lit("mvi_t1", vec(8'h00, 1, 0, 8'h04, 0, 0, 0, 0, 1, 2'd1));
      cyc(1, 0, 16'h0000); lit("mvi_end", c_zero);

      // mv R1,R6
      cyc(1, 1, enc(3'd0, 3'd1, 3'd6)); lit("mv_t0", c_ir);
      cyc(1, 0, 16'h0000); lit("mv_t1", vec(8'h40, 0, 0, 8'h02, 0, 0, 0, 0, 1, 2'd1));
      cyc(1, 0, 16'h0000); lit("mv_end", c_zero);

      // sub R3,R4 with run/din noise after acceptance
      cyc(1, 1, enc(3'd3, 3'd3, 3'd4)); lit("sub_t0", c_ir);
      cyc(1, 1, 16'hFFFF); lit("sub_t1", vec(8'h08, 0, 0, 8'h00, 1, 0, 0, 0, 0, 2'd1));
      cyc(1, 1, 16'hFFFF); lit("sub_t2", vec(8'h10, 0, 0, 8'h00, 0, 1, 1, 0, 0, 2'd2));
      cyc(1, 0, 16'h0000); lit("sub_t3", vec(8'h00, 0, 1, 8'h08, 0, 0, 0, 0, 1, 2'd3));

      // add R3,R4
      cyc(1, 1, enc(3'd2, 3'd3, 3'd4));
      cyc(1, 0, 16'h0000);
      cyc(1, 0, 16'h0000); lit("add_t2", vec(8'h10, 0, 0, 8'h00, 0, 1, 0, 0, 0, 2'd2));
      cyc(1, 0, 16'h0000); lit("add_t3", vec(8'h00, 0, 1, 8'h08, 0, 0, 0, 0, 1, 2'd3));

      // NOP
      cyc(1, 1, enc(3'd6, 3'd7, 3'd7));
      cyc(1, 0, 16'h0000); lit("nop_t1", vec(8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 2'd1));

      // Back-to-back: add R5,R7 then mv R0,R0 with run held high
      cyc(1, 1, enc(3'd2, 3'd5, 3'd7));
      cyc(1, 1, 16'h0000);
      cyc(1, 1, 16'h0000);
      cyc(1, 1, 16'h0000); lit("b2b_done", vec(8'h00, 0, 1, 8'h20, 0, 0, 0, 0, 1, 2'd3));
      cyc(1, 1, enc(3'd0, 3'd0, 3'd0)); lit("b2b_ir", c_ir);
      cyc(1, 0, 16'h0000); lit("mv_r0r0", vec(8'h01, 0, 0, 8'h01, 0, 0, 0, 0, 1, 2'd1));

      // Reset during T2 of add R1,R2
      cyc(1, 1, enc(3'd2, 3'd1, 3'd2));
      cyc(1, 0, 16'h0000);
      cyc(0, 0, 16'h0000); lit("rst_in_t2", c_zero);
      cyc(1, 0, 16'h0000); lit("rst_after", c_zero);
      cyc(1, 1, enc(3'd0, 3'd4, 3'd5)); lit("fresh_t0", c_ir);
      cyc(1, 0, 16'h0000); lit("fresh_t1", vec(8'h20, 0, 0, 8'h10, 0, 0, 0, 0, 1, 2'd1));

      // Random instruction stream, run mostly high, rare resets
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), 16'($urandom));
      end

      cyc(1, 0, 16'h0000);
      cyc(1, 0, 16'h0000);
      @(negedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
